// File: rtl/cva5_fifo_ext_if.sv
// rtl/cva5_fifo_ext_if.sv - Handshake/status bundle for the cva5_fifo_ext buffer.
interface cva5_fifo_ext_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 6
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  full;
    logic [CW-1:0]         count;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  flush, push, data_in, pop,
        output data_out, valid, full, count, almost_full, almost_empty, overflow, underflow
    );

    modport master (
        output flush, push, data_in, pop,
        input  data_out, valid, full, count, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/cva5_fifo_ext.sv
// rtl/cva5_fifo_ext.sv - First-word-fall-through FIFO of arbitrary depth with status and error pulses.
module cva5_fifo_ext #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 6,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int SAFE       = 1
) (
    input logic             clk,
    input logic             rst,
    cva5_fifo_ext_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_valid;
    logic                  w_push_eff;
    logic                  w_pop_eff;
    logic [PW-1:0]         w_rd_ptr_inc;
    logic [PW-1:0]         w_wr_ptr_inc;
    logic [CW-1:0]         w_count_next;

    always_comb begin
        w_full     = (r_count == FULL_CNT);
        w_valid    = (r_count != '0);
        w_push_eff = bus.push & ~bus.flush;
        w_pop_eff  = bus.pop & ~bus.flush;
        if (SAFE != 0) begin
            w_push_eff = bus.push & (~w_full | bus.pop) & ~bus.flush;
            w_pop_eff  = bus.pop & w_valid & ~bus.flush;
        end
        // Explicit wrap so non-power-of-2 depths use exactly DEPTH slots.
        w_rd_ptr_inc = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
        w_wr_ptr_inc = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
        w_count_next = r_count + CW'(w_push_eff) - CW'(w_pop_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.push & w_full & ~bus.pop & ~bus.flush;
            r_underflow <= bus.pop & ~w_valid & ~bus.flush;
            if (bus.flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_eff) r_wr_ptr <= w_wr_ptr_inc;
                if (w_pop_eff)  r_rd_ptr <= w_rd_ptr_inc;
                r_count <= w_count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_eff) r_mem[r_wr_ptr] <= bus.data_in;
    end

    assign bus.data_out     = r_mem[r_rd_ptr];
    assign bus.valid        = w_valid;
    assign bus.full         = w_full;
    assign bus.count        = r_count;
    assign bus.almost_full  = (int'(r_count) >= AF_THRESH);
    assign bus.almost_empty = (int'(r_count) <= AE_THRESH);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

    // A write into a full FIFO is only legal when the head is leaving in the same cycle.
    a_no_overwrite: assert property (@(posedge clk) disable iff (rst || SAFE == 0)
        !(w_push_eff && w_full && !w_pop_eff));
    a_count_range: assert property (@(posedge clk) disable iff (rst || SAFE == 0)
        r_count <= FULL_CNT);
endmodule

// File: doc/cva5_fifo_ext.md
Name: cva5_fifo_ext

Overview:
- Generalised small FIFO for CVA5 unit-to-unit buffering.
- Supports any depth ≥1, including non-power-of-2 depths, without rounding storage up.
- Adds occupancy count, almost-full/almost-empty thresholds, synchronous flush, optional overflow/underflow protection and error pulses.
- First-word-fall-through: the head entry is always presented on data_out while valid.

Parameters:
- DATA_WIDTH, 32: entry width in bits.
- DEPTH, 6: number of entries; legal range ≥1.
- AF_THRESH, DEPTH-1: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH.
- SAFE, 1:
  - 1: illegal push/pop are dropped.
  - 0: no protection; storage behaviour on illegal requests is undefined, but error flags still fire.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all contents
- push  in  1  enqueue data_in this cycle
- data_in  in  DATA_WIDTH  write data
- pop  in  1  dequeue head this cycle
- data_out  out  DATA_WIDTH  head entry; valid only when valid=1
- valid  out  1  FIFO non-empty
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH+1)  current occupancy
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- overflow  out  1  one-cycle pulse: illegal push occurred last cycle
- underflow  out  1  one-cycle pulse: illegal pop occurred last cycle

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Reset values: count=0, read/write pointers=0, valid=0, full=0, almost_full=(AF_THRESH==0), almost_empty=1, overflow=0, underflow=0.
  - data_out is don't-care while valid=0.
  - Reset mid-operation discards all entries at the next edge.
- Storage and pointers:
  - Storage is DEPTH registers/LUTRAM entries.
  - Read and write pointers are binary, range 0..DEPTH-1, and wrap DEPTH-1 → 0 with an explicit compare (not power-of-2 modulo).
  - DEPTH==1: single register plus valid bit; the pointers are degenerate.
- Effective operations:
  - push_eff = push & (~full | pop) & ~flush when SAFE; push & ~flush otherwise.
  - pop_eff = pop & valid & ~flush when SAFE; pop & ~flush otherwise.
- Occupancy:
  - count_next = count + push_eff − pop_eff.
  - All status outputs are decoded from the registered count, so they change only the cycle after the causing edge.
- Latency:
  - An entry pushed at edge t is visible on data_out from cycle t+1 if the FIFO was empty.
  - No same-cycle bypass: push into an empty FIFO with pop asserted → pop is illegal (underflow); the push is still accepted.
- Simultaneous push+pop:
  - When full: legal; count stays DEPTH, head advances, new entry written at the freed slot.
  - When partially filled: count unchanged, both pointers advance.
- Flush:
  - Next cycle count=0, pointers=0.
  - Push or pop in the flush cycle is ignored and raises no error flag.
  - rst has priority over flush.
- Error flags (registered, asserted in cycle t+1 for one cycle):
  - overflow = push & full & ~pop & ~flush at cycle t.
  - underflow = pop & ~valid & ~flush at cycle t.
- data_out is read asynchronously from storage at the read pointer and holds stable while no pop occurs.
- Assertions: push_eff never writes into an occupied slot; count never exceeds DEPTH.

Test Plan (DEPTH=6, AF_THRESH=5, AE_THRESH=1, SAFE=1, DATA_WIDTH=32 unless stated):
- Fill/drain: push 0x10..0x15 over 6 cycles → count 1..6, almost_full from count=5, full at 6. Then pop 6 cycles → data_out 0x10..0x15 in order, valid drops after the 6th pop.
- Wrap-around: 4 push, 4 pop, 6 push (0xA0..0xA5), 6 pop → output order 0xA0..0xA5 correct across the pointer wrap at index 5→0.
- Full with push+pop: at count=6 assert push=0xBB and pop together → head pops, count stays 6, no overflow; 0xBB emerges as the 6th pop thereafter.
- Protection: at count=6 push 0xCC alone → count stays 6, overflow pulses 1 cycle, 0xCC is never output. At count=0 pop alone → underflow pulse, count stays 0.
- Flush: count=3, assert flush with push=0xDD → next cycle count=0, valid=0, no error pulse. A subsequent push 0xEE appears on data_out next cycle.
- DEPTH=1 and DEPTH=5 builds: repeat fill/drain and wrap → identical ordering; full at count=1 and count=5 respectively.
